// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake into the boot loader: the host drives data/valid,
// the loader answers with ready.
interface imem_boot_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them to
// instruction memory while holding the core in reset, then hands over to fetch.
//
// state  | meaning
// S_HDR  | collecting the length word N
// S_DATA | collecting program words, one memory write per completed word
// S_LAST | writing the final word, byte stream paused
// S_RUN  | core released, memory address follows fetch_addr
// S_ERR  | N exceeded memory capacity, waiting for reload
module imem_boot_loader #(
   parameter int INSTR_MEM_SIZE_BYTES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   imem_boot_loader_if.slave    rx,
   input  logic                 reload,
   input  logic [31:0]          fetch_addr,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   output logic                 mem_we,
   output logic                 cpu_rst_n,
   output logic                 load_done,
   output logic                 load_err,
   output logic [15:0]          words_loaded
);

   localparam int          DEPTH   = INSTR_MEM_SIZE_BYTES / 4;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
      S_LAST,
      S_RUN,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] n_q, n_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;
   logic        load_done_q, load_done_d;
   logic        load_err_q, load_err_d;

   logic        rx_ready;
   logic        accept;
   logic        word_done;
   logic [31:0] word_full;

   assign rx_ready  = (state_q == S_HDR) || (state_q == S_DATA);
   assign rx.rx_ready = rx_ready;
   assign accept    = rx.rx_valid && rx_ready;
   assign word_done = accept && (byte_cnt_q == 2'd3);
   assign word_full = {rx.rx_data, asm_q[23:0]};

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
      n_d         = n_q;
      we_d        = 1'b0;
      wdata_d     = wdata_q;
      wcnt_d      = wcnt_q + {15'd0, we_q};
      cpu_rst_n_d = cpu_rst_n_q;

      if (accept) begin
         byte_cnt_d = 2'(byte_cnt_q + 2'd1);
         asm_d[{byte_cnt_q, 3'b000} +: 8] = rx.rx_data;
      end

      case (state_q)
         S_HDR: begin
            if (word_done) begin
               if (word_full == 32'd0) begin
                  state_d     = S_RUN;
                  cpu_rst_n_d = 1'b1;
               end else if (word_full > DEPTH_W) begin
                  state_d = S_ERR;
               end else begin
                  n_d     = word_full;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (word_done) begin
               we_d    = 1'b1;
               wdata_d = word_full;
               // wcnt_q already counts every earlier word: their writes finished
               // at least three cycles before this completion.
               if (({16'd0, wcnt_q} + 32'd1) == n_q) begin
                  state_d = S_LAST;
               end
            end
         end
         S_LAST: begin
            state_d     = S_RUN;
            cpu_rst_n_d = 1'b1;
         end
         S_RUN, S_ERR: begin
            if (reload) begin
               state_d     = S_HDR;
               cpu_rst_n_d = 1'b0;
               wcnt_d      = 16'd0;
               byte_cnt_d  = 2'd0;
               asm_d       = 32'd0;
            end
         end
         default: begin
            state_d     = S_HDR;
            cpu_rst_n_d = 1'b0;
         end
      endcase

      load_done_d = (state_d == S_RUN);
      load_err_d  = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HDR;
         byte_cnt_q  <= 2'd0;
         asm_q       <= 32'd0;
         n_q         <= 32'd0;
         we_q        <= 1'b0;
         wdata_q     <= 32'd0;
         wcnt_q      <= 16'd0;
         cpu_rst_n_q <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         n_q         <= n_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         wcnt_q      <= wcnt_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem_addr     = (state_q == S_RUN) ? fetch_addr : {14'd0, wcnt_q, 2'b00};
   assign mem_wdata    = wdata_q;
   assign mem_we       = we_q;
   assign cpu_rst_n    = cpu_rst_n_q;
   assign load_done    = load_done_q;
   assign load_err     = load_err_q;
   assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: byte streams with hand-computed writes,
// memory model fed by observed write pulses.
module tb_imem_boot_loader;

   logic        clk;
   logic        rst_n;
   logic        reload;
   logic [31:0] fetch_addr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        cpu_rst_n;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   imem_boot_loader_if rx ();

   imem_boot_loader #(.INSTR_MEM_SIZE_BYTES(1024)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .reload       (reload),
      .fetch_addr   (fetch_addr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .cpu_rst_n    (cpu_rst_n),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] wr_addr [$];
   logic [31:0] wr_data [$];
   logic [31:0] mem_m [256];

   initial begin
      for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
   end

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         mem_m[mem_addr[9:2]] = mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx.rx_valid = 1'b0;
      rx.rx_data = 8'h00;
      reload = 1'b0;
      #12;
      rst_n = 1'b1;
      tick(1);
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      tick(1);
      reload = 1'b0;
   endtask

   // Presents one byte and returns #1 after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      t = 0;
      rx.rx_data  = b;
      rx.rx_valid = 1'b1;
      while (rx.rx_ready !== 1'b1 && t < 50) begin
         tick(1);
         t++;
      end
      if (rx.rx_ready !== 1'b1) begin
         chk("rx_ready_timeout", {31'd0, rx.rx_ready}, 32'd1);
      end else begin
         tick(1);
      end
      if (gap) begin
         rx.rx_valid = 1'b0;
         tick(1);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      logic [31:0] tmp;
      tmp = w;
      for (int k = 0; k < 4; k++) send_byte(tmp[8*k +: 8], gap);
   endtask

   task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d);
      if (idx < wr_addr.size()) begin
         chk($sformatf("wr%0d_addr", idx), wr_addr[idx], a);
         chk($sformatf("wr%0d_data", idx), wr_data[idx], d);
      end else begin
         chk($sformatf("wr%0d_missing", idx), 32'(wr_addr.size()), 32'(idx + 1));
      end
   endtask

   task automatic chk_fetch(input logic [31:0] a, input logic [31:0] d);
      fetch_addr = a;
      #1;
      chk("fetch_mem_addr", mem_addr, a);
      chk("fetch_read", mem_m[mem_addr[9:2]], d);
   endtask

   task automatic load_three(input bit gap);
      send_word(32'd3, gap);
      send_word(32'h00500093, gap);
      send_word(32'h00a00113, gap);
      send_word(32'h002081b3, gap);
      rx.rx_data = 8'hff;
      tick(4);
   endtask

   task automatic chk_three(input string tag);
      chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'd3);
      chk_wr(0, 32'h0, 32'h00500093);
      chk_wr(1, 32'h4, 32'h00a00113);
      chk_wr(2, 32'h8, 32'h002081b3);
      chk({tag, "_load_done"}, {31'd0, load_done}, 32'd1);
      chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
      chk({tag, "_words"}, {16'd0, words_loaded}, 32'd3);
      chk({tag, "_rx_ready"}, {31'd0, rx.rx_ready}, 32'd0);
      chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
      chk_fetch(32'h0, 32'h00500093);
      chk_fetch(32'h4, 32'h00a00113);
      chk_fetch(32'h8, 32'h002081b3);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
      chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
      chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
      chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      reload = 1'b0;
      fetch_addr = 32'h0000_1234;
      rx.rx_valid = 1'b0;
      rx.rx_data = 8'h00;
      #3;
      chk_reset_outs("rst");
      do_reset();
      chk("rst_rx_ready", {31'd0, rx.rx_ready}, 32'd1);

      // 3-word program, valid held high
      load_three(1'b0);
      rx.rx_valid = 1'b0;
      chk_three("held");

      // same program, valid toggling
      do_reset();
      load_three(1'b1);
      rx.rx_valid = 1'b0;
      chk_three("toggle");

      // oversize header, then recover with a zero-length header
      do_reset();
      send_word(32'd257, 1'b0);
      rx.rx_valid = 1'b0;
      tick(3);
      chk("err_load_err", {31'd0, load_err}, 32'd1);
      chk("err_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      chk("err_rx_ready", {31'd0, rx.rx_ready}, 32'd0);
      chk("err_load_done", {31'd0, load_done}, 32'd0);
      chk("err_wr_count", 32'(wr_addr.size()), 32'd0);
      pulse_reload();
      chk("err_reload_rx_ready", {31'd0, rx.rx_ready}, 32'd1);
      chk("err_reload_load_err", {31'd0, load_err}, 32'd0);
      send_word(32'd0, 1'b0);
      rx.rx_valid = 1'b0;
      chk("err_rec_load_done", {31'd0, load_done}, 32'd1);
      chk("err_rec_words", {16'd0, words_loaded}, 32'd0);
      chk("err_rec_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

      // zero-length header
      do_reset();
      send_word(32'd0, 1'b0);
      rx.rx_valid = 1'b0;
      chk("zero_load_done", {31'd0, load_done}, 32'd1);
      chk("zero_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
      fetch_addr = 32'h10;
      #1;
      chk("zero_mem_addr", mem_addr, 32'h10);
      tick(3);
      chk("zero_wr_count", 32'(wr_addr.size()), 32'd0);

      // reset mid-load after a completed program left mem_wdata non-zero
      do_reset();
      load_three(1'b0);
      rx.rx_valid = 1'b0;
      pulse_reload();
      chk("mid_reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      send_word(32'd3, 1'b0);
      send_byte(8'h93, 1'b0);
      send_byte(8'h00, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      #4;
      rx.rx_valid = 1'b0;
      rst_n = 1'b1;
      tick(1);
      wr_addr.delete();
      wr_data.delete();
      load_three(1'b0);
      rx.rx_valid = 1'b0;
      chk_three("fresh");

      // reload from RUN with a 1-word program
      wr_addr.delete();
      wr_data.delete();
      pulse_reload();
      chk("rl_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      chk("rl_load_done", {31'd0, load_done}, 32'd0);
      chk("rl_words", {16'd0, words_loaded}, 32'd0);
      chk("rl_mem_addr", mem_addr, 32'd0);
      send_word(32'd1, 1'b0);
      send_word(32'hdeadbeef, 1'b0);
      rx.rx_valid = 1'b0;
      tick(3);
      chk("rl_wr_count", 32'(wr_addr.size()), 32'd1);
      chk_wr(0, 32'h0, 32'hdeadbeef);
      chk("rl_cpu_rst_n_run", {31'd0, cpu_rst_n}, 32'd1);
      chk("rl_words_run", {16'd0, words_loaded}, 32'd1);
      chk_fetch(32'h0, 32'hdeadbeef);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the instruction memory.
- Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes those words sequentially into the instruction memory while holding the CPU core in reset.
- Once loading completes, it hands the memory address port to the fetch stage and releases the core.

Parameters:
INSTR_MEM_SIZE_BYTES, 1024, size of instruction memory in bytes; capacity DEPTH = INSTR_MEM_SIZE_BYTES/4 words.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader can accept a byte this cycle
reload  input  1  single-cycle pulse; restarts loading from RUN or ERR
fetch_addr  input  32  byte address from the IF stage
mem_addr  output  32  byte address to instruction memory
mem_wdata  output  32  write data to instruction memory
mem_we  output  1  write enable to instruction memory
cpu_rst_n  output  1  active-low reset for the core; registered
load_done  output  1  high while in RUN
load_err  output  1  high while in ERR
words_loaded  output  16  count of words written since the last HDR entry

Behaviour:
- Reset (async, rst_n=0):
  - state=HDR; byte counter and word counter cleared; assembly register cleared.
  - Outputs: mem_we=0, mem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0, words_loaded=0.
  - rx_ready=1 from the first cycle after release.
  - Reset asserted mid-load abandons the load; no partial word is written.
- Byte acceptance:
  - A byte is accepted on a rising edge where rx_valid && rx_ready.
  - The byte counter (0..3) selects the lane: byte k goes to bits [8k+7:8k].
  - The 4th accepted byte completes a word; the byte counter wraps to 0.
- Stalls: rx_valid low for any number of cycles simply stalls the loader; there is no timeout.
- States:
  - HDR:
    - rx_ready=1. The first completed word is the program length N (words).
    - N==0 -> RUN.
    - N>DEPTH -> ERR.
    - Otherwise latch N and go to DATA.
  - DATA:
    - rx_ready=1. On completion of a word, the next cycle drives mem_we=1 for exactly one cycle, with mem_addr=words_loaded*4 and mem_wdata=the word. words_loaded increments in that same cycle.
    - Byte acceptance continues in parallel with that write.
    - When the completed word is word N-1, go to LAST instead of staying in DATA.
  - LAST:
    - One cycle. rx_ready=0, mem_we=1, final word written at (N-1)*4.
    - Next state is RUN.
  - RUN:
    - rx_ready=0, mem_we=0, load_done=1.
    - cpu_rst_n=1, registered: it goes high on the edge entering RUN.
    - mem_addr=fetch_addr combinationally; mem_wdata holds its last value.
    - reload=1 -> HDR: cpu_rst_n=0 on the next edge, words_loaded=0, counters cleared.
  - ERR:
    - rx_ready=0, cpu_rst_n=0, load_err=1.
    - Only reload or rst_n exits ERR (to HDR).
- Address mux:
  - mem_addr=fetch_addr exactly when state==RUN.
  - Otherwise mem_addr is the registered write address (words_loaded*4), which is 0 in HDR.
- reload:
  - Ignored in HDR, DATA and LAST.
  - In RUN or ERR it takes effect in a single cycle.
- Width rules:
  - N is compared as a full 32-bit unsigned value against DEPTH.
  - words_loaded never exceeds DEPTH, so 16 bits suffice for DEPTH up to 65535.
  - Write addresses are word-aligned (low 2 bits 0).
- Simultaneous events:
  - The 4th byte of the last word together with rx_valid held high: no further byte is accepted, because rx_ready=0 in LAST and RUN.
  - A write pulse and a new byte acceptance in the same cycle are both honoured.

Test Plan:
- Reset then stream 03 00 00 00, 93 00 50 00, 13 01 a0 00, b3 81 20 00 with rx_valid held high -> mem_we pulses 3 times:
  - addr 0x0 data 0x00500093;
  - addr 0x4 data 0x00a00113;
  - addr 0x8 data 0x002081b3.
  - Then load_done=1, cpu_rst_n=1, words_loaded=3, rx_ready=0.
  - Reading the memory at fetch_addr 0x0/0x4/0x8 returns those words.
- Same stream with rx_valid toggling 1/0 every cycle -> identical writes and final state; no byte lost or duplicated.
- Header 01 01 00 00 (N=257 > DEPTH=256) -> ERR, load_err=1, cpu_rst_n=0, rx_ready=0, no mem_we. Then pulse reload and send header 00 00 00 00 -> RUN with words_loaded=0.
- Header 00 00 00 00 -> RUN immediately after 4th byte; mem_we never asserted; mem_addr tracks fetch_addr (drive 0x10 -> mem_addr=0x10).
- Assert rst_n=0 after 6 bytes of a 3-word load -> all outputs at reset values asynchronously. After release, a full fresh load writes from address 0x0.
- In RUN, pulse reload and stream a 1-word program deadbeef (ef be ad de) -> cpu_rst_n low the cycle after reload; write addr 0x0 data 0xdeadbeef; RUN re-entered with cpu_rst_n=1.
